cache_ctrl: RTL

Control FSM for the set-associative write-back cache. It sequences the tag, valid, data and dirty arrays for one CPU request at a time, and services misses through the physical-memory port. A miss writes back a dirty victim first, then fills. The block owns the dirty array's `operation`/`way_sel` controls and the PLRU update strobe.

---
 rtl/cache_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/cache_ctrl.sv
// cache_ctrl
//
// Control FSM for a set-associative write-back cache. It handles one CPU
// request at a time and sequences the tag, valid, data and dirty arrays. It
// services misses over the physical-memory port: a dirty victim is written
// back first, then the line is filled. After the fill, the controller
// compares again, and that compare hits and finishes the request.
//
// Optional feature macro: CACHE_CTRL_PERF_EN
//   defined   -> hit_count / miss_count are saturating 32-bit counters
//   undefined -> both ports are tied to zero and no counter flops exist
//
// Ports:
//   clk            sole clock, rising edge
//   rst            asynchronous active-low reset
//   mem_read       CPU read request, held until mem_resp
//   mem_write      CPU write request, held until mem_resp (wins over read)
//   mem_resp       one-cycle completion pulse to the CPU
//   hit            tag compare hit for the current set
//   hit_way        matching way when hit is high
//   victim_way     PLRU replacement choice for the current set
//   dirty_in       dirty bit of the way on way_sel
//   dirty_op       dirty array operation: 00 idle, 01 mark, 10 unmark
//   way_sel        way addressed by the data/tag/valid/dirty arrays
//   data_we        data array write enable
//   data_src       0 = CPU write data with byte enables, 1 = pmem line
//   tag_we         tag write plus valid set for way_sel
//   plru_update    PLRU touch of way_sel
//   pmem_addr_sel  0 = CPU address, 1 = writeback address
//   pmem_read      line fill request, held until pmem_resp
//   pmem_write     line writeback request, held until pmem_resp
//   pmem_resp      pmem completion pulse
//   hit_count      hits counted (live only with the perf macro)
//   miss_count     misses counted (live only with the perf macro)

module cache_ctrl #(
    parameter int s_index = 4,
    parameter int w_index = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_read,
    input  logic               mem_write,
    output logic               mem_resp,
    input  logic               hit,
    input  logic [w_index-1:0] hit_way,
    input  logic [w_index-1:0] victim_way,
    input  logic               dirty_in,
    output logic [1:0]         dirty_op,
    output logic [w_index-1:0] way_sel,
    output logic               data_we,
    output logic               data_src,
    output logic               tag_we,
    output logic               plru_update,
    output logic               pmem_addr_sel,
    output logic               pmem_read,
    output logic               pmem_write,
    input  logic               pmem_resp,
    output logic [31:0]        hit_count,
    output logic [31:0]        miss_count
);

    // The set index never reaches the controller. It is checked here only so
    // that a degenerate configuration fails at elaboration.
    if (s_index < 1 || w_index < 1) begin : g_bad_params
        $error("cache_ctrl: s_index and w_index must both be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        FILL      = 2'd3
    } state_t;

    localparam logic [1:0] DIRTY_IDLE   = 2'b00;
    localparam logic [1:0] DIRTY_MARK   = 2'b01;
    localparam logic [1:0] DIRTY_UNMARK = 2'b10;

    state_t             state_q, state_d;
    logic [w_index-1:0] vway_q, vway_d;

    logic req;
    logic is_write;

    assign req      = mem_read | mem_write;
    assign is_write = mem_write;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            vway_q  <= '0;
        end else begin
            state_q <= state_d;
            vway_q  <= vway_d;
        end
    end

    // Next-state and Mealy outputs. The victim register is loaded only on the
    // COMPARE miss cycle, so a victim_way that changes during WRITEBACK/FILL
    // cannot redirect the fill to a different way.
    always_comb begin
        state_d       = state_q;
        vway_d        = vway_q;
        mem_resp      = 1'b0;
        dirty_op      = DIRTY_IDLE;
        way_sel       = '0;
        data_we       = 1'b0;
        data_src      = 1'b0;
        tag_we        = 1'b0;
        plru_update   = 1'b0;
        pmem_addr_sel = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = COMPARE;
                end
            end

            COMPARE: begin
                way_sel = hit ? hit_way : victim_way;
                if (!req) begin
                    // The CPU abandoned the request during the fill.
                    state_d = IDLE;
                end else if (hit) begin
                    mem_resp    = 1'b1;
                    plru_update = 1'b1;
                    if (is_write) begin
                        data_we  = 1'b1;
                        data_src = 1'b0;
                        dirty_op = DIRTY_MARK;
                    end
                    state_d = IDLE;
                end else begin
                    vway_d  = victim_way;
                    state_d = dirty_in ? WRITEBACK : FILL;
                end
            end

            WRITEBACK: begin
                way_sel       = vway_q;
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
                if (pmem_resp) begin
                    dirty_op = DIRTY_UNMARK;
                    state_d  = FILL;
                end
            end

            FILL: begin
                way_sel       = vway_q;
                pmem_read     = 1'b1;
                pmem_addr_sel = 1'b0;
                if (pmem_resp) begin
                    data_we  = 1'b1;
                    data_src = 1'b1;
                    tag_we   = 1'b1;
                    state_d  = COMPARE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef CACHE_CTRL_PERF_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;
    logic        hit_evt;
    logic        miss_evt;

    // A hit is counted only when it completes a request. A miss is counted on
    // the COMPARE cycle that leaves for WRITEBACK or FILL. The re-compare
    // after a fill therefore counts as one hit.
    assign hit_evt  = (state_q == COMPARE) && req && hit;
    assign miss_evt = (state_q == COMPARE) && req && !hit;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (hit_evt && (hit_count_q != 32'hFFFF_FFFF)) begin
            hit_count_d = hit_count_q + 32'd1;
        end
        if (miss_evt && (miss_count_q != 32'hFFFF_FFFF)) begin
            miss_count_d = miss_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`else
    assign hit_count  = 32'd0;
    assign miss_count = 32'd0;
`endif

endmodule
